// File: rtl/sc_loader_pkg.sv
// Shared definitions for the serial register loader: FSM state encoding and default bus width.
// Optional even-parity trailer bit is enabled by defining SC_LOADER_PARITY_EN.
package sc_loader_pkg;

  localparam int DEFAULT_DATAWIDTH_BUS = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY,
    S_WRITE  = ST_WRITE
  } loader_state_t;

endpackage

// File: rtl/sc_loader_shifter.sv
// MSB-first shift register with saturating bit counter and last-bit flag.
// With SC_LOADER_PARITY_EN defined it also keeps the running XOR of accepted bits.
module sc_loader_shifter
  import sc_loader_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEFAULT_DATAWIDTH_BUS
) (
  input  logic                     SC_RegGENERAL_CLOCK_50,
  input  logic                     SC_RegGENERAL_Reset_InHigh,
  input  logic                     clr_in,
  input  logic                     shift_in,
  input  logic                     bit_in,
  output logic [DATAWIDTH_BUS-1:0] word_next_out,
  output logic                     last_bit_out
`ifdef SC_LOADER_PARITY_EN
  ,
  output logic [DATAWIDTH_BUS-1:0] word_out,
  output logic                     parity_out
`endif
);

  localparam int CNT_W = $clog2(DATAWIDTH_BUS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATAWIDTH_BUS - 1);

  logic [DATAWIDTH_BUS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr_in) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_in) begin
      shreg_d = {shreg_q[DATAWIDTH_BUS-2:0], bit_in};
      // Saturates: the FSM leaves SHIFT on the last bit, so no wrap inside a frame.
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_next_out = {shreg_q[DATAWIDTH_BUS-2:0], bit_in};
  assign last_bit_out  = (cnt_q == CNT_LAST);

`ifdef SC_LOADER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (clr_in)        par_d = 1'b0;
    else if (shift_in) par_d = par_q ^ bit_in;
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) par_q <= 1'b0;
    else                            par_q <= par_d;
  end

  assign word_out   = shreg_q;
  assign parity_out = par_q;
`endif

endmodule

// File: rtl/sc_serial_reg_loader.sv
// Serial-to-parallel loader feeding the write-enabled register: MSB-first assembly, one-cycle active-low strobe.
// Define SC_LOADER_PARITY_EN to require an even-parity bit after each word.
module sc_serial_reg_loader
  import sc_loader_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEFAULT_DATAWIDTH_BUS
) (
  input  logic                     SC_RegGENERAL_CLOCK_50,
  input  logic                     SC_RegGENERAL_Reset_InHigh,
  input  logic                     sc_loader_start_in,
  input  logic                     sc_loader_bit_in,
  input  logic                     sc_loader_bit_valid_in,
  output logic [DATAWIDTH_BUS-1:0] sc_loader_DataBUS_Out,
  output logic                     sc_loader_Write_OutLow,
  output logic                     sc_loader_busy_out,
  output logic                     sc_loader_frame_err_out,
  output logic                     sc_loader_parity_err_out
);

  // Handshake: a bit is taken on every rising edge where bit_valid is high while a
  // frame is shifting; there is no back-pressure, and start overrides a same-cycle bit.

  loader_state_t            state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic                     write_n_q, write_n_d;
  logic                     busy_q, busy_d;
  logic                     frame_err_q, frame_err_d;
  logic                     clr, shift_en, last_bit;
  logic [DATAWIDTH_BUS-1:0] word_next;
`ifdef SC_LOADER_PARITY_EN
  logic [DATAWIDTH_BUS-1:0] word_cur;
  logic                     run_par;
  logic                     parity_err_q, parity_err_d;
`endif

  sc_loader_shifter #(.DATAWIDTH_BUS(DATAWIDTH_BUS)) u_shifter (
    .SC_RegGENERAL_CLOCK_50     (SC_RegGENERAL_CLOCK_50),
    .SC_RegGENERAL_Reset_InHigh (SC_RegGENERAL_Reset_InHigh),
    .clr_in                     (clr),
    .shift_in                   (shift_en),
    .bit_in                     (sc_loader_bit_in),
    .word_next_out              (word_next),
    .last_bit_out               (last_bit)
`ifdef SC_LOADER_PARITY_EN
    ,
    .word_out                   (word_cur),
    .parity_out                 (run_par)
`endif
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    write_n_d   = 1'b1;
    frame_err_d = frame_err_q;
    clr         = 1'b0;
    shift_en    = 1'b0;
`ifdef SC_LOADER_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sc_loader_start_in) begin
          clr         = 1'b1;
          frame_err_d = 1'b0;
`ifdef SC_LOADER_PARITY_EN
          parity_err_d = 1'b0;
`endif
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sc_loader_start_in) begin
          clr         = 1'b1;
          frame_err_d = 1'b1;
          state_d     = S_SHIFT;
        end else if (sc_loader_bit_valid_in) begin
          shift_en = 1'b1;
          if (last_bit) begin
`ifdef SC_LOADER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d   = S_WRITE;
            write_n_d = 1'b0;
            data_d    = word_next;
`endif
          end
        end
      end
`ifdef SC_LOADER_PARITY_EN
      S_PARITY: begin
        if (sc_loader_start_in) begin
          clr         = 1'b1;
          frame_err_d = 1'b1;
          state_d     = S_SHIFT;
        end else if (sc_loader_bit_valid_in) begin
          if (run_par == sc_loader_bit_in) begin
            state_d   = S_WRITE;
            write_n_d = 1'b0;
            data_d    = word_cur;
          end else begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
`endif
      S_WRITE: begin
        // Strobe lasts this one cycle; a start seen now opens the next frame directly.
        clr = 1'b1;
        if (sc_loader_start_in) begin
          frame_err_d = 1'b0;
`ifdef SC_LOADER_PARITY_EN
          parity_err_d = 1'b0;
`endif
          state_d     = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      write_n_q   <= 1'b1;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      write_n_q   <= write_n_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SC_LOADER_PARITY_EN
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) parity_err_q <= 1'b0;
    else                            parity_err_q <= parity_err_d;
  end
  assign sc_loader_parity_err_out = parity_err_q;
`else
  assign sc_loader_parity_err_out = 1'b0;
`endif

  assign sc_loader_DataBUS_Out   = data_q;
  assign sc_loader_Write_OutLow  = write_n_q;
  assign sc_loader_busy_out      = busy_q;
  assign sc_loader_frame_err_out = frame_err_q;

endmodule

// File: tb/tb_sc_serial_reg_loader.sv
// Directed bench for sc_serial_reg_loader: frame-level model checked every cycle plus literal checkpoints.
// Honours SC_LOADER_PARITY_EN the same way the design does.
module tb_sc_serial_reg_loader;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sbit;
  logic         valid;
  logic [W-1:0] dut_data;
  logic         dut_wn;
  logic         dut_busy;
  logic         dut_ferr;
  logic         dut_perr;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_strobes = 0;
  logic prev_wn = 1'b1;
  logic [W-1:0] exp_q[$];

  sc_serial_reg_loader #(.DATAWIDTH_BUS(W)) dut (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_Reset_InHigh (rst),
    .sc_loader_start_in         (start),
    .sc_loader_bit_in           (sbit),
    .sc_loader_bit_valid_in     (valid),
    .sc_loader_DataBUS_Out      (dut_data),
    .sc_loader_Write_OutLow     (dut_wn),
    .sc_loader_busy_out         (dut_busy),
    .sc_loader_frame_err_out    (dut_ferr),
    .sc_loader_parity_err_out   (dut_perr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic         m_active   = 1'b0;
  logic         m_wait_par = 1'b0;
  int           m_nbits    = 0;
  logic [W-1:0] m_word     = '0;
  logic         m_strobe   = 1'b0;
  logic [W-1:0] m_data     = '0;
  logic         m_ferr     = 1'b0;
  logic         m_perr     = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_wait_par = 1'b0; m_nbits = 0; m_word = '0;
      m_strobe = 1'b0; m_data = '0; m_ferr = 1'b0; m_perr = 1'b0;
    end else begin
      m_strobe = 1'b0;
      if (start) begin
        m_ferr = m_active;
        m_perr = 1'b0;
        m_active = 1'b1; m_wait_par = 1'b0; m_nbits = 0; m_word = '0;
      end else if (m_active && valid) begin
        if (m_wait_par) begin
          m_active = 1'b0;
          if ((^m_word) == sbit) begin
            m_strobe = 1'b1;
            m_data = m_word;
          end else begin
            m_perr = 1'b1;
          end
        end else begin
          m_word = {m_word[W-2:0], sbit};
          m_nbits++;
          if (m_nbits == W) begin
`ifdef SC_LOADER_PARITY_EN
            m_wait_par = 1'b1;
`else
            m_active = 1'b0;
            m_strobe = 1'b1;
            m_data = m_word;
`endif
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("write_n", dut_wn, !m_strobe);
      check("data", dut_data, m_data);
      check("busy", dut_busy, m_active || m_strobe);
      check("frame_err", dut_ferr, m_ferr);
      check("parity_err", dut_perr, m_perr);
      if (!dut_wn) begin
        n_strobes++;
        check("strobe_width", prev_wn, 1'b1);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          check("sb_word", dut_data, exp_q.pop_front());
        end
      end
      prev_wn = dut_wn;
    end else begin
      prev_wn = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic v, input logic b);
    @(negedge clk);
    start = s; valid = v; sbit = b;
  endtask

  task automatic quiet(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_start();
    drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, v[i]);
  endtask

  task automatic send_par(input logic p);
`ifdef SC_LOADER_PARITY_EN
    drive(1'b0, 1'b1, p);
`else
    if (p) begin end
`endif
  endtask

  // Full good frame; returns at the cycle the strobe must be visible.
  task automatic good_frame(input logic [W-1:0] v, input logic p);
    exp_q.push_back(v);
    send_start();
    send_bits(32'(v), W);
    send_par(p);
    quiet(1);
    check("latency_wn", dut_wn, 1'b0);
    check("latency_data", dut_data, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; sbit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", dut_data, 8'h00);
    check("rst_wn", dut_wn, 1'b1);
    check("rst_busy", dut_busy, 1'b0);
    check("rst_ferr", dut_ferr, 1'b0);
    check("rst_perr", dut_perr, 1'b0);

    // Basic 0xA5 load
    good_frame(8'hA5, 1'b0);
    quiet(1);
    check("basic_wn_after", dut_wn, 1'b1);
    check("basic_busy_after", dut_busy, 1'b0);
    check("basic_data_hold", dut_data, 8'hA5);

    // Stall of 5 cycles between bits 3 and 4
    exp_q.push_back(8'hA5);
    send_start();
    send_bits(32'b101, 3);
    quiet(5);
    check("stall_busy", dut_busy, 1'b1);
    check("stall_wn", dut_wn, 1'b1);
    send_bits(32'b00101, 5);
    send_par(1'b0);
    quiet(1);
    check("stall_wn_low", dut_wn, 1'b0);
    check("stall_data", dut_data, 8'hA5);
    quiet(2);

    // Abort then 0x3C; the restart start also overrides a valid bit
    exp_q.push_back(8'h3C);
    send_start();
    send_bits(32'b1100, 4);
    drive(1'b1, 1'b1, 1'b1);
    send_bits(32'h3C, W);
    send_par(1'b0);
    quiet(1);
    check("abort_wn", dut_wn, 1'b0);
    check("abort_data", dut_data, 8'h3C);
    check("abort_ferr", dut_ferr, 1'b1);
    quiet(2);
    check("abort_ferr_sticky", dut_ferr, 1'b1);
    check("abort_busy", dut_busy, 1'b0);

    // Start during the strobe cycle goes straight into the next frame
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h0F);
    send_start();
    send_bits(32'h5A, W);
    send_par(1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("wr_start_wn", dut_wn, 1'b0);
    check("wr_start_data", dut_data, 8'h5A);
    send_bits(32'h0F, W);
    send_par(1'b0);
    quiet(1);
    check("back2back_data", dut_data, 8'h0F);
    check("back2back_ferr", dut_ferr, 1'b0);
    quiet(1);

    // Boundary words
    good_frame(8'hFF, 1'b0);
    good_frame(8'h01, 1'b1);
    quiet(1);

    // Reset mid-frame after a completed 0xA5 write
    good_frame(8'hA5, 1'b0);
    send_start();
    send_bits(32'b10110, 5);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data", dut_data, 8'h00);
    check("midrst_wn", dut_wn, 1'b1);
    check("midrst_busy", dut_busy, 1'b0);
    quiet(3);

`ifdef SC_LOADER_PARITY_EN
    good_frame(8'hA5, 1'b0);
    quiet(1);
    send_start();
    send_bits(32'hA5, W);
    send_par(1'b1);
    quiet(1);
    check("par_bad_wn", dut_wn, 1'b1);
    check("par_bad_perr", dut_perr, 1'b1);
    check("par_bad_data", dut_data, 8'hA5);
    check("par_bad_busy", dut_busy, 1'b0);
    quiet(2);
    check("par_sticky", dut_perr, 1'b1);
    send_start();
    quiet(1);
    check("par_clr_on_start", dut_perr, 1'b0);
    quiet(1);
`endif

    quiet(2);
    check("sb_drained", exp_q.size(), 0);
`ifdef SC_LOADER_PARITY_EN
    check("strobe_total", n_strobes, 9);
`else
    check("strobe_total", n_strobes, 8);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_serial_reg_loader.md
Name: sc_serial_reg_loader

Overview:
- Serial-to-parallel front end placed directly upstream of the team's general-purpose write-enabled register.
- Assembles DATAWIDTH_BUS serial bits, MSB first, into a parallel word.
- Presents the word on a parallel data bus and issues a single-cycle active-low write strobe that the downstream register consumes.
- Lets slow serial sources (switch debouncer, bit-bang port) load the register file.

Parameters:
- DATAWIDTH_BUS, 8, width of the assembled word and output bus; legal range 2..32.
- CNT_W, $clog2(DATAWIDTH_BUS), bit-counter width; localparam, not overridable.

Ports:
- SC_RegGENERAL_CLOCK_50  input  1  system clock; all logic on rising edge.
- SC_RegGENERAL_Reset_InHigh  input  1  asynchronous, active-high reset.
- sc_loader_start_in  input  1  frame start; sampled every cycle.
- sc_loader_bit_in  input  1  serial data bit, valid when sc_loader_bit_valid_in=1.
- sc_loader_bit_valid_in  input  1  bit strobe; one bit accepted per cycle when high.
- sc_loader_DataBUS_Out  output  DATAWIDTH_BUS  assembled word, drives the register data input.
- sc_loader_Write_OutLow  output  1  active-low write strobe to the register.
- sc_loader_busy_out  output  1  frame in progress.
- sc_loader_frame_err_out  output  1  sticky abort flag.
- sc_loader_parity_err_out  output  1  sticky parity flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous): state=IDLE, shift register=0, counter=0, DataBUS_Out=0, Write_OutLow=1, busy=0, frame_err=0, parity_err=0. Reset mid-frame discards the partial word; no strobe is issued.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, SHIFT, PARITY (feature only), WRITE.
- IDLE:
  - busy=0.
  - start=1 clears the shift register and counter, clears frame_err and parity_err, and moves to SHIFT.
  - bit_valid is ignored.
- SHIFT:
  - busy=1.
  - When bit_valid=1: shreg <= {shreg[W-2:0], bit_in} and counter++.
  - When bit_valid=1 and counter==W-1: go to WRITE, or to PARITY if the feature is enabled.
  - bit_valid=0 stalls indefinitely; there is no timeout.
- start=1 while in SHIFT or PARITY:
  - Abort the current frame, set frame_err=1, clear the shift register and counter, and stay in or re-enter SHIFT as a fresh frame.
  - The start pulse wins over a simultaneous bit_valid; that bit is dropped.
- WRITE:
  - For exactly one cycle: Write_OutLow=0 and DataBUS_Out=assembled word (updated in the same edge), busy=1.
  - Next cycle: Write_OutLow=1, return to IDLE.
  - start=1 during WRITE is honoured after the strobe; the FSM goes straight to SHIFT instead of IDLE.
- Latency: the strobe goes low on the clock edge after the last data bit is accepted (1 cycle), or after the parity bit when the feature is enabled.
- DataBUS_Out holds the last written word until the next WRITE. It is never updated on an aborted or parity-failed frame.
- Write_OutLow is never low for more than one consecutive cycle.
- Counter saturates at W-1 and resets on start or WRITE; no wrap-around is possible within a frame.

Optional Feature:
- Macro: SC_LOADER_PARITY_EN.
- Defined:
  - After W data bits, SHIFT goes to PARITY and waits for one more bit_valid carrying an even-parity bit.
  - Parity match (XOR of data bits equals the parity bit) goes to WRITE.
  - Mismatch sets parity_err=1 (sticky until next start), goes to IDLE, and issues no strobe.
- Undefined: no PARITY state and no parity logic; sc_loader_parity_err_out is driven constant 0; the port list is unchanged.

Decomposition:
- Shared package sc_loader_pkg:
  - 2-bit FSM state encoding localparams: IDLE=0, SHIFT=1, PARITY=2, WRITE=3.
  - Default DATAWIDTH_BUS.
- One natural sub-module, sc_loader_shifter:
  - Contains the shift register plus bit counter, with clear/shift enables and a last-bit flag.
  - Also computes the running parity.
  - The FSM and output registers stay in the top module.

Test Plan:
- Reset then idle: assert reset for 3 cycles, release -> DataBUS_Out=0x00, Write_OutLow=1, busy=0, all flags 0.
- Basic load (W=8): start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles -> exactly one cycle with Write_OutLow=0 and DataBUS_Out=0xA5, one cycle after the 8th bit; busy=0 afterwards.
- Stalled bits: same 0xA5 frame with bit_valid deasserted for 5 cycles between bits 3 and 4 -> same 0xA5 single strobe; busy stays 1 through the stall.
- Abort: start, 4 bits, start again, then 8 bits of 0x3C -> frame_err=1, one strobe only, DataBUS_Out=0x3C.
- Reset mid-frame: after 5 bits of a frame that follows a completed 0xA5 write, pulse reset -> no strobe, DataBUS_Out=0x00, state IDLE.
- Parity (macro defined): 0xA5 with parity bit 0 -> strobe with 0xA5. 0xA5 with parity bit 1 -> no strobe, parity_err=1, DataBUS_Out unchanged.
